piano_voice_mixer: RTL and testbench



---
 rtl/piano_voice_mixer.sv | 99 +++++++++
 tb/tb_piano_voice_mixer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piano_voice_mixer.sv
// piano_voice_mixer: eight-voice linear attack/release envelope mixer that
// sums the gated voices once per 255-cycle PWM frame and drives a single
// registered PWM speaker pin.
module piano_voice_mixer #(
    parameter int ENV_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] voice,
    input  logic [7:0] key_en,
    output logic       pwm_out,
    output logic       sample_strobe,
    output logic [3:0] active_count
);

    // Prescaler width covers 0..ENV_DIV-1 (ENV_DIV legal 2..65536).
    localparam int            PW        = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(ENV_DIV - 1);
    localparam logic [7:0]    PCNT_LAST = 8'd254;
    localparam logic [3:0]    LVL_MAX   = 4'd15;

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [3:0]    lvl_q [8];
    logic [3:0]    lvl_d [8];
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          strobe_q, strobe_d;
    logic [3:0]    act_q, act_d;

    logic          env_tick;
    logic          frame_end;
    logic [6:0]    mix_sum;

    assign env_tick  = (pre_q == PRE_LAST);
    assign frame_end = (pcnt_q == PCNT_LAST);

    // Next-state logic: counters, envelopes, frame mix, compare and popcount.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no latch inferred).
        pre_d    = env_tick ? '0 : pre_q + PW'(1);
        pcnt_d   = frame_end ? 8'd0 : pcnt_q + 8'd1;
        mix_sum  = 7'd0;
        act_d    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            lvl_d[i] = lvl_q[i];
            if (env_tick) begin
                if (key_en[i] && (lvl_q[i] != LVL_MAX)) begin
                    lvl_d[i] = lvl_q[i] + 4'd1;
                end else if (!key_en[i] && (lvl_q[i] != 4'd0)) begin
                    lvl_d[i] = lvl_q[i] - 4'd1;
                end
            end
            // Mix uses the pre-tick level, so a coincident tick lands next frame.
            mix_sum = mix_sum + (voice[i] ? {3'b000, lvl_q[i]} : 7'd0);
            act_d   = act_d + ((lvl_q[i] != 4'd0) ? 4'd1 : 4'd0);
        end
        // Max mix is 120, doubled to 240: always below the 255-cycle frame.
        duty_d   = frame_end ? {mix_sum, 1'b0} : duty_q;
        pwm_d    = (pcnt_q < duty_q);
        // Registered strobe is high exactly while pcnt_q sits at 254.
        strobe_d = (pcnt_d == PCNT_LAST);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            pre_q    <= '0;
            pcnt_q   <= 8'd0;
            duty_q   <= 8'd0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
            act_q    <= 4'd0;
            // NOTE: the level array is small and must read as silent straight
            // out of reset, so it is reset like any other register.
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= 4'd0;
            end
        end else begin
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            strobe_q <= strobe_d;
            act_q    <= act_d;
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign pwm_out       = pwm_q;
    assign sample_strobe = strobe_q;
    assign active_count  = act_q;

endmodule

// File: tb/tb_piano_voice_mixer.sv
// Testbench for piano_voice_mixer: directed scenarios plus a random phase,
// checked by a scoreboard fed from an abstract envelope/frame model.
module tb_piano_voice_mixer;

    localparam int ENV_DIV = 4;
    localparam int FRAME   = 255;

    logic       clk;
    logic       rst_n;
    logic [7:0] voice;
    logic [7:0] key_en;
    logic       pwm_out;
    logic       sample_strobe;
    logic [3:0] active_count;

    piano_voice_mixer #(.ENV_DIV(ENV_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .voice        (voice),
        .key_en       (key_en),
        .pwm_out      (pwm_out),
        .sample_strobe(sample_strobe),
        .active_count (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame position, prescaler phase, level per voice and the duty in force.
    typedef struct {
        bit pwm;
        bit strobe;
        int act;
    } cyc_exp_t;

    cyc_exp_t cyc_q[$];
    int       high_q[$];
    int       m_pos, m_pre, m_duty;
    int       m_lvl [8];
    bit       rst_seen;
    int       m_act, m_sum;
    cyc_exp_t m_e;

    // Advance the model by one clock edge and queue the expected outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos  = 0;
            m_pre  = 0;
            m_duty = 0;
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
            high_q.delete();
            high_q.push_back(0);
            m_e.pwm = 0; m_e.strobe = 0; m_e.act = 0;
            cyc_q.push_back(m_e);
            rst_seen = 1;
        end else begin
            m_act = 0;
            for (int i = 0; i < 8; i++) if (m_lvl[i] != 0) m_act++;
            m_e.pwm = (m_pos < m_duty);
            if (m_pos == FRAME - 1) begin
                m_sum = 0;
                for (int i = 0; i < 8; i++) if (voice[i]) m_sum += m_lvl[i];
                m_duty = 2 * m_sum;
                high_q.push_back(m_duty);
            end
            if (m_pre == ENV_DIV - 1) begin
                for (int i = 0; i < 8; i++) begin
                    if (key_en[i] && m_lvl[i] < 15) m_lvl[i]++;
                    else if (!key_en[i] && m_lvl[i] > 0) m_lvl[i]--;
                end
            end
            m_pre = (m_pre + 1) % ENV_DIV;
            m_pos = (m_pos + 1) % FRAME;
            m_e.strobe = (m_pos == FRAME - 1);
            m_e.act    = m_act;
            cyc_q.push_back(m_e);
            rst_seen = 0;
        end
    end

    // ---------------- monitor ----------------
    int       hi_cnt, since_rst, last_high, frame_id;
    bit       prev_strobe, first_pend;
    int       exp_high;
    cyc_exp_t mon_e;

    // Compare each cycle's outputs and each frame's high-cycle count.
    always @(negedge clk) begin
        if (cyc_q.size() == 0) begin
            check("cycle_expectation_present", 0, 1);
        end else begin
            mon_e = cyc_q.pop_front();
            check("pwm_out", {31'b0, pwm_out}, {31'b0, mon_e.pwm});
            check("sample_strobe", {31'b0, sample_strobe}, {31'b0, mon_e.strobe});
            check("active_count", {28'b0, active_count}, mon_e.act);
        end
        if (rst_seen) begin
            hi_cnt      = 0;
            prev_strobe = 0;
            since_rst   = 1;
            first_pend  = 1;
        end else begin
            since_rst++;
            if (pwm_out === 1'b1) hi_cnt++;
            if (prev_strobe) begin
                if (high_q.size() == 0) begin
                    check("frame_expectation_present", 0, 1);
                end else begin
                    exp_high = high_q.pop_front();
                    check("frame_high_cycles", hi_cnt, exp_high);
                end
                last_high = hi_cnt;
                frame_id++;
                hi_cnt = 0;
            end
            prev_strobe = (sample_strobe === 1'b1);
            if (sample_strobe === 1'b1 && first_pend) begin
                // Post-reset cycle (pcnt 0) counts as cycle 1; strobe at pcnt 254.
                check("first_strobe_cycle", since_rst, FRAME);
                first_pend = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frames(input int n);
        int start;
        int budget;
        start  = frame_id;
        budget = n * FRAME + 600;
        while (frame_id < start + n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (frame_id < start + n) check("frame_wait_timeout", 0, 1);
        #1;
    endtask

    initial begin
        hi_cnt = 0; since_rst = 0; last_high = 0; frame_id = 0;
        prev_strobe = 0; first_pend = 0; rst_seen = 0;
        rst_n  = 1'b0;
        key_en = 8'hFF;
        voice  = 8'hFF;

        // Reset held for 5 cycles with every key and voice active.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_pwm_out", {31'b0, pwm_out}, 0);
            check("rst_active_count", {28'b0, active_count}, 0);
            check("rst_sample_strobe", {31'b0, sample_strobe}, 0);
        end

        // Single voice attack to saturation: duty 30.
        rst_n = 1'b1; key_en = 8'h01; voice = 8'h01;
        wait_frames(3);
        check("single_voice_high_cycles", last_high, 30);
        check("single_voice_active", {28'b0, active_count}, 1);

        // Full chord at saturation: duty 240.
        key_en = 8'hFF; voice = 8'hFF;
        wait_frames(3);
        check("chord_high_cycles", last_high, 240);
        check("chord_active", {28'b0, active_count}, 8);

        // Voice gating: all levels full but every voice low.
        voice = 8'h00;
        wait_frames(3);
        check("gated_high_cycles", last_high, 0);
        check("gated_active", {28'b0, active_count}, 8);

        // Reset in the middle of a duty-240 frame.
        voice = 8'hFF;
        wait_frames(2);
        check("pre_reset_high_cycles", last_high, 240);
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (m_pos == 100) break;
            @(posedge clk); #1;
        end
        check("reached_pcnt_100", m_pos, 100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_pwm_out", {31'b0, pwm_out}, 0);
        check("midrst_active", {28'b0, active_count}, 0);
        check("midrst_strobe", {31'b0, sample_strobe}, 0);

        // Release mid-attack: 7 attack ticks to level 7, then 7 release ticks.
        rst_n = 1'b1; key_en = 8'h08; voice = 8'h08;
        repeat (28) @(posedge clk);
        #1;
        check("mid_attack_active", {28'b0, active_count}, 1);
        key_en = 8'h00;
        repeat (28) @(posedge clk);
        @(negedge clk);
        check("release_last_level_active", {28'b0, active_count}, 1);
        @(negedge clk);
        check("release_done_active", {28'b0, active_count}, 0);

        // Random keys and voices against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 15) == 0) key_en = 8'($urandom);
            voice = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
